ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the Execute stage, alongside the main ALU. It accepts an M-extension operation (funct7 = 0000001) from the ID/EX register and computes the 32-bit result over multiple cycles. It raises a stall so that the pipeline holds the instruction in EX until a one-cycle `done` pulse delivers the result to the EX/MEM result mux. Single-cycle ALU ops continue to be decoded by the ALU control path; this block only handles M-extension ops.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_negate.sv | 19 +
 rtl/ex_muldiv.sv | 190 +++++++++++++++++++
 tb/tb_ex_muldiv.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and state encoding for the RV32M multiply/divide unit
//
// Purpose: funct3 opcodes of the M extension, the iterative FSM state type and
// the fixed iteration count shared by ex_muldiv and its testbench.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int MULDIV_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_negate.sv
// rtl/muldiv_negate.sv - combinational conditional two's-complement negate
//
// Purpose: returns -i_val when i_neg is set, i_val otherwise. Used for operand
// absolute values and for sign correction of the final product/quotient/remainder.
// Ports:
//   i_neg  in  1  negate when high
//   i_val  in  W  value
//   o_val  out W  i_neg ? -i_val : i_val
module muldiv_negate #(
  parameter int W = 64
) (
  input  logic         i_neg,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative RV32M multiply/divide unit for the Execute stage
//
// Purpose: accepts an M-extension op, computes it one bit per cycle (32 cycles)
// or via a fast path for divide-by-zero / signed overflow, stalls the pipeline
// meanwhile and pulses done with the registered result.
// Ports:
//   clk      in  1     core clock
//   rst_n    in  1     asynchronous active-low reset
//   start    in  1     M-op present in EX (held while stalled)
//   flush    in  1     synchronous abort of the op in EX
//   funct3   in  3     M-op selector
//   rs1_val  in  XLEN  operand A (multiplicand/dividend)
//   rs2_val  in  XLEN  operand B (multiplier/divisor)
//   stall    out 1     hold the pipeline (combinational, state based)
//   done     out 1     one-cycle result-valid pulse
//   result   out XLEN  registered result, held between ops
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_e r_state;
  muldiv_state_e w_next_state;

  logic [5:0]        r_cnt;
  logic [2:0]        r_f3;
  logic              r_sign_a;
  logic              r_sign_b;
  logic [XLEN-1:0]   r_a;        // |multiplicand|
  logic [XLEN-1:0]   r_b;        // |divisor|
  logic [2*XLEN-1:0] r_acc;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic              r_done;
  logic [XLEN-1:0]   r_result;

  logic              w_sign_a;
  logic              w_sign_b;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic              w_accept;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_result;
  logic              w_last;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_trial;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_mul_next;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_acc_next;
  logic [2*XLEN-1:0] w_fix_in;
  logic              w_fix_neg;
  logic [2*XLEN-1:0] w_fixed;
  logic [XLEN-1:0]   w_calc_result;

  // Only signed operands are made absolute: MULH both, MULHSU rs1, DIV/REM both.
  assign w_sign_a = rs1_val[XLEN-1] &
                    ((funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                     (funct3 == F3_DIV)  || (funct3 == F3_REM));
  assign w_sign_b = rs2_val[XLEN-1] &
                    ((funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM));

  muldiv_negate #(.W(XLEN)) u_abs_a (.i_neg(w_sign_a), .i_val(rs1_val), .o_val(w_abs_a));
  muldiv_negate #(.W(XLEN)) u_abs_b (.i_neg(w_sign_b), .i_val(rs2_val), .o_val(w_abs_b));

  assign w_accept = (r_state == IDLE) & start & ~flush;

  assign w_div0 = funct3[2] & (rs2_val == '0);
  assign w_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &
                  (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_val == '1);
  assign w_fast = w_div0 | w_ovf;

  // funct3[1] separates REM/REMU from DIV/DIVU.
  always_comb begin
    w_fast_result = '0;
    if (w_div0) begin
      w_fast_result = (funct3 == F3_REM || funct3 == F3_REMU) ? rs1_val : '1;
    end else if (w_ovf) begin
      w_fast_result = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // Radix-2 shift-add: add multiplicand to the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right (carry kept).
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

  // Restoring division: shift next dividend bit into the remainder and keep the
  // subtraction only when it does not borrow.
  assign w_trial    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff     = w_trial - {1'b0, r_b};
  assign w_div_next = w_diff[XLEN] ? {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

  assign w_acc_next = r_f3[2] ? w_div_next : w_mul_next;

  // The final iteration's value feeds sign correction directly so the result
  // is registered on the same edge that enters DONE.
  always_comb begin
    w_fix_in  = w_acc_next;
    w_fix_neg = r_sign_a ^ r_sign_b;
    if (r_f3[2]) begin
      if (r_f3[1]) begin
        w_fix_in  = {{XLEN{1'b0}}, w_acc_next[2*XLEN-1:XLEN]};
        w_fix_neg = r_sign_a;
      end else begin
        w_fix_in  = {{XLEN{1'b0}}, w_acc_next[XLEN-1:0]};
      end
    end
  end

  muldiv_negate #(.W(2*XLEN)) u_fix (.i_neg(w_fix_neg), .i_val(w_fix_in), .o_val(w_fixed));

  always_comb begin
    w_calc_result = w_fixed[XLEN-1:0];
    case (r_f3)
      F3_MULH, F3_MULHSU, F3_MULHU: w_calc_result = w_fixed[2*XLEN-1:XLEN];
      default:                      w_calc_result = w_fixed[XLEN-1:0];
    endcase
  end

  assign w_last = (r_state == CALC) && (r_cnt == 6'(MULDIV_CYCLES - 1));

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = w_fast ? DONE : CALC;
      CALC:    if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
    if (flush) w_next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_f3     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= (w_next_state == DONE);
      if (w_accept) begin
        r_f3     <= funct3;
        r_sign_a <= w_sign_a;
        r_sign_b <= w_sign_b;
        r_a      <= w_abs_a;
        r_b      <= w_abs_b;
        r_cnt    <= '0;
        r_acc    <= funct3[2] ? {{XLEN{1'b0}}, w_abs_a} : {{XLEN{1'b0}}, w_abs_b};
        if (w_fast) r_result <= w_fast_result;
      end else if ((r_state == CALC) && !flush) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt + 6'd1;
        if (w_last) r_result <= w_calc_result;
      end
    end
  end

  // Reset gating keeps stall low while rst_n is asserted even with start held.
  assign stall  = rst_n & ((start & (r_state == IDLE) & ~flush) | (r_state == CALC));
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .flush   (flush),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .stall   (stall),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues an op in the current cycle (cycle 0), holds start while stalled,
  // and checks latency, stall cycles and result. Returns one cycle after done.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
    int n;
    int stall_cnt;
    start   = 1'b1;
    funct3  = f3;
    rs1_val = a;
    rs2_val = b;
    #1;
    n = 0;
    stall_cnt = 0;
    while (!done && n < 40) begin
      if (stall) stall_cnt++;
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, " latency"}, n, exp_lat);
    check({tag, " stall_cycles"}, stall_cnt, exp_lat);
    check({tag, " stall_at_done"}, {31'b0, stall}, 32'd0);
    check({tag, " result"}, result, exp_res);
    tick();
    check({tag, " done_width"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    flush   = 1'b0;
    funct3  = 3'b000;
    rs1_val = 32'd0;
    rs2_val = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset stall", {31'b0, stall}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("mul_7x-3",    F3_MUL,    32'd7,        32'hFFFF_FFFD, 33, 32'hFFFF_FFEB);
    run_op("mulh_-1x-1",  F3_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'h0000_0000);
    run_op("mulhsu_-1",   F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFF);
    run_op("mulhu_max",   F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
    run_op("mulh_min2",   F3_MULH,   32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000);
    run_op("div_-7/2",    F3_DIV,    32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFD);
    run_op("rem_-7/2",    F3_REM,    32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF);
    run_op("div_7/-2",    F3_DIV,    32'd7,        32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
    run_op("rem_7/-2",    F3_REM,    32'd7,        32'hFFFF_FFFE, 33, 32'd1);
    run_op("divu_100/7",  F3_DIVU,   32'd100,      32'd7,         33, 32'd14);
    run_op("remu_100/7",  F3_REMU,   32'd100,      32'd7,         33, 32'd2);

    // Flush a DIVU in cycle 10: no done, result keeps 2, then MUL from cycle 11.
    start   = 1'b1;
    funct3  = F3_DIVU;
    rs1_val = 32'd100;
    rs2_val = 32'd7;
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    start = 1'b0;
    #1;
    check("flush stall_c11", {31'b0, stall}, 32'd0);
    check("flush done_c11", {31'b0, done}, 32'd0);
    check("flush result_kept", result, 32'd2);
    run_op("mul_3x4_after_flush", F3_MUL, 32'd3, 32'd4, 33, 32'd12);

    run_op("divu_5/0",    F3_DIVU,   32'd5,        32'd0,         1, 32'hFFFF_FFFF);
    run_op("rem_5/0",     F3_REM,    32'd5,        32'd0,         1, 32'd5);
    run_op("div_ovf",     F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
    run_op("rem_ovf",     F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

    // Async reset in cycle 15 of a MUL, start held through and after release.
    start   = 1'b1;
    funct3  = F3_MUL;
    rs1_val = 32'd7;
    rs2_val = 32'd5;
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid done", {31'b0, done}, 32'd0);
    check("rst_mid result", result, 32'd0);
    check("rst_mid stall", {31'b0, stall}, 32'd0);
    tick();
    rst_n = 1'b1;
    run_op("mul_after_reset", F3_MUL, 32'd7, 32'd5, 33, 32'd35);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
